i2c_reg_access: RTL and testbench

Register-access sequencer that sits directly upstream of `i2c_master`. It accepts single-register write or read commands over a valid/ready interface and drives the master's byte-level transfer handshake: START, address, register pointer, data, STOP. It returns one response per command, carrying read data and error flags. Reads use a write-pointer transaction with STOP, followed by a separate read transaction. No repeated START is used.

---
 rtl/i2c_reg_access_if.sv | 47 ++++
 rtl/i2c_reg_access.sv | 193 +++++++++++++++++++
 tb/tb_i2c_reg_access.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_access_if.sv
// Command/response and i2c_master byte-handshake signals for i2c_reg_access.
interface i2c_reg_access_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_read;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err_nack;
    logic       rsp_err_arb;
    logic       rsp_err_timeout;

    logic       m_transfer_ready;
    logic       m_interrupt;
    logic       m_transaction_complete;
    logic       m_nack;
    logic       m_start_err;
    logic       m_arbitration_err;
    logic [7:0] m_data_rx;
    logic [7:0] m_address;
    logic       m_transfer_start;
    logic       m_transfer_continues;
    logic [7:0] m_data_tx;

    // Sequencer view: accepts commands, drives the master handshake
    modport slave (
        input  cmd_valid, cmd_read, cmd_dev_addr, cmd_reg, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err_nack, rsp_err_arb, rsp_err_timeout,
        input  m_transfer_ready, m_interrupt, m_transaction_complete, m_nack,
        input  m_start_err, m_arbitration_err, m_data_rx,
        output m_address, m_transfer_start, m_transfer_continues, m_data_tx
    );

    // Environment view: command source plus the i2c_master side
    modport master (
        output cmd_valid, cmd_read, cmd_dev_addr, cmd_reg, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err_nack, rsp_err_arb, rsp_err_timeout,
        output m_transfer_ready, m_interrupt, m_transaction_complete, m_nack,
        output m_start_err, m_arbitration_err, m_data_rx,
        input  m_address, m_transfer_start, m_transfer_continues, m_data_tx
    );
endinterface

// File: rtl/i2c_reg_access.sv
// Single-register read/write sequencer driving the byte-level handshake of i2c_master.
// Reads are a pointer write with STOP followed by a separate one-byte read transaction.
module i2c_reg_access #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic              clk_in,
    input logic              reset,
    i2c_reg_access_if.slave  bus
);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, PTR, WDATA, GAP, RADDR, RDATA, DRAIN, RESP
    } state_t;

    state_t              state, state_n;
    logic [WDOG_W-1:0]   wdog, wdog_n;
    logic                rd_q, rd_n;
    logic [6:0]          dev_q, dev_n;
    logic [7:0]          reg_q, reg_n;
    logic [7:0]          wdata_q, wdata_n;
    logic [7:0]          addr_q, addr_n;
    logic [7:0]          tx_q, tx_n;
    logic                start_q, start_n;
    logic                cont_q, cont_n;
    logic                rsp_valid_q, rsp_valid_n;
    logic [7:0]          rdata_q, rdata_n;
    logic                nack_q, nack_n;
    logic                arb_q, arb_n;
    logic                to_q, to_n;
    logic                fail;

    logic accept, irq_arb, ok_base, ok_full, expired;

    assign bus.cmd_ready = (state == IDLE) && bus.m_transfer_ready && !reset;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign irq_arb       = bus.m_start_err || bus.m_arbitration_err;
    assign ok_base       = !bus.m_nack && !irq_arb;
    assign ok_full       = ok_base && bus.m_transaction_complete;
    // An interrupt in the expiry cycle counts as progress
    assign expired       = (wdog == WDOG_W'(TIMEOUT_CYCLES)) && !bus.m_interrupt;

    // Next-state and registered-output logic
    always_comb begin
        state_n     = state;
        rd_n        = rd_q;
        dev_n       = dev_q;
        reg_n       = reg_q;
        wdata_n     = wdata_q;
        addr_n      = addr_q;
        tx_n        = tx_q;
        start_n     = start_q;
        cont_n      = cont_q;
        rdata_n     = rdata_q;
        nack_n      = nack_q;
        arb_n       = arb_q;
        to_n        = to_q;
        fail        = 1'b0;
        rsp_valid_n = 1'b0;
        wdog_n      = '0;

        case (state)
            IDLE: if (accept) begin
                rd_n    = bus.cmd_read;
                dev_n   = bus.cmd_dev_addr;
                reg_n   = bus.cmd_reg;
                wdata_n = bus.cmd_wdata;
                rdata_n = 8'h00;
                nack_n  = 1'b0;
                arb_n   = 1'b0;
                to_n    = 1'b0;
                addr_n  = {bus.cmd_dev_addr, 1'b0};
                start_n = 1'b1;
                cont_n  = 1'b1;
                state_n = ADDR;
            end
            ADDR: if (bus.m_interrupt) begin
                if (ok_base) begin
                    start_n = 1'b0;
                    tx_n    = reg_q;
                    cont_n  = !rd_q;
                    state_n = PTR;
                end else fail = 1'b1;
            end
            PTR: if (bus.m_interrupt) begin
                if (!ok_full)   fail = 1'b1;
                else if (rd_q)  state_n = GAP;
                else begin
                    tx_n    = wdata_q;
                    cont_n  = 1'b0;
                    state_n = WDATA;
                end
            end
            WDATA: if (bus.m_interrupt) begin
                if (ok_full) state_n = DRAIN;
                else         fail = 1'b1;
            end
            GAP: if (bus.m_transfer_ready) begin
                addr_n  = {dev_q, 1'b1};
                start_n = 1'b1;
                cont_n  = 1'b1;
                state_n = RADDR;
            end
            RADDR: if (bus.m_interrupt) begin
                if (ok_base) begin
                    start_n = 1'b0;
                    cont_n  = 1'b0;
                    state_n = RDATA;
                end else fail = 1'b1;
            end
            // The master NACKs the single read byte itself, so m_nack is expected here
            RDATA: if (bus.m_interrupt) begin
                if (!irq_arb && bus.m_transaction_complete) begin
                    rdata_n = bus.m_data_rx;
                    state_n = DRAIN;
                end else fail = 1'b1;
            end
            DRAIN: begin
                start_n = 1'b0;
                cont_n  = 1'b0;
                if (bus.m_transfer_ready) state_n = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (fail) begin
            if (irq_arb) arb_n  = 1'b1;
            else         nack_n = 1'b1;
            start_n = 1'b0;
            cont_n  = 1'b0;
            state_n = DRAIN;
        end

        if (expired && state != IDLE && state != RESP) begin
            to_n    = 1'b1;
            start_n = 1'b0;
            cont_n  = 1'b0;
            state_n = RESP;
        end

        rsp_valid_n = (state_n == RESP);

        if (state != IDLE && state_n == state && !bus.m_interrupt)
            wdog_n = wdog + 1'b1;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wdog        <= '0;
            rd_q        <= 1'b0;
            dev_q       <= 7'h00;
            reg_q       <= 8'h00;
            wdata_q     <= 8'h00;
            addr_q      <= 8'h00;
            tx_q        <= 8'h00;
            start_q     <= 1'b0;
            cont_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
            nack_q      <= 1'b0;
            arb_q       <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state       <= state_n;
            wdog        <= wdog_n;
            rd_q        <= rd_n;
            dev_q       <= dev_n;
            reg_q       <= reg_n;
            wdata_q     <= wdata_n;
            addr_q      <= addr_n;
            tx_q        <= tx_n;
            start_q     <= start_n;
            cont_q      <= cont_n;
            rsp_valid_q <= rsp_valid_n;
            rdata_q     <= rdata_n;
            nack_q      <= nack_n;
            arb_q       <= arb_n;
            to_q        <= to_n;
        end
    end

    assign bus.rsp_valid            = rsp_valid_q;
    assign bus.rsp_rdata            = rdata_q;
    assign bus.rsp_err_nack         = nack_q;
    assign bus.rsp_err_arb          = arb_q;
    assign bus.rsp_err_timeout      = to_q;
    assign bus.m_address            = addr_q;
    assign bus.m_transfer_start     = start_q;
    assign bus.m_transfer_continues = cont_q;
    assign bus.m_data_tx            = tx_q;
endmodule

// File: tb/tb_i2c_reg_access.sv
// Scoreboard bench for i2c_reg_access: a byte-level i2c_master model logs bus tokens and
// a response monitor checks each rsp_valid against queued expectations.
`timescale 1ns/1ps
module tb_i2c_reg_access;
    localparam int unsigned TO = 64;
    localparam int TOK_START = 256;
    localparam int TOK_STOP  = 257;
    localparam int TOK_RNACK = 258;
    localparam int TOK_RACK  = 259;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    i2c_reg_access_if bus();
    i2c_reg_access #(.TIMEOUT_CYCLES(TO)) dut (.clk_in(clk_in), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    int          bus_q[$];
    logic [10:0] rsp_q[$];   // {rdata, err_nack, err_arb, err_timeout}

    int         nack_idx = -1;
    int         arb_idx  = -1;
    bit         hang     = 1'b0;
    logic [7:0] slave_rd = 8'h00;
    int         cur_byte = -1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic log_bus(input int tok);
        int e;
        if (bus_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL bus_token: got 0x%0h, expected nothing", tok);
        end else begin
            e = bus_q.pop_front();
            check("bus_token", tok, e);
        end
    endtask

    // One byte boundary: pulse m_interrupt with the slave's status
    task automatic byte_done(input int idx, input logic rd_byte, input logic mnack, output logic ack);
        logic arb, nk;
        arb = (idx == arb_idx);
        nk  = rd_byte ? mnack : ((idx == nack_idx) || arb);
        bus.m_interrupt            = 1'b1;
        bus.m_nack                 = nk;
        bus.m_arbitration_err      = arb;
        bus.m_start_err            = 1'b0;
        bus.m_transaction_complete = 1'b1;
        bus.m_data_rx              = rd_byte ? slave_rd : 8'h00;
        @(negedge clk_in);
        bus.m_interrupt            = 1'b0;
        bus.m_nack                 = 1'b0;
        bus.m_arbitration_err      = 1'b0;
        bus.m_transaction_complete = 1'b0;
        ack = !nk && !arb;
    endtask

    task automatic run_txn();
        logic rd, c, ack;
        int idx;
        bus.m_transfer_ready = 1'b0;
        log_bus(TOK_START);
        log_bus(int'(bus.m_address));
        rd = bus.m_address[0];
        c  = bus.m_transfer_continues;
        if (hang) begin
            repeat (100) @(negedge clk_in);
            bus.m_transfer_ready = 1'b1;
            return;
        end
        idx = 0;
        repeat (4) @(negedge clk_in);
        byte_done(idx, 1'b0, 1'b0, ack);
        while (ack && c) begin
            idx++;
            repeat (2) @(negedge clk_in);
            c = bus.m_transfer_continues;
            if (rd) log_bus(c ? TOK_RACK : TOK_RNACK);
            else    log_bus(int'(bus.m_data_tx));
            cur_byte = idx;
            repeat (4) @(negedge clk_in);
            byte_done(idx, rd, !c, ack);
        end
        cur_byte = -1;
        repeat (2) @(negedge clk_in);
        log_bus(TOK_STOP);
        bus.m_transfer_ready = 1'b1;
    endtask

    initial begin : master_model
        bus.m_transfer_ready       = 1'b1;
        bus.m_interrupt            = 1'b0;
        bus.m_transaction_complete = 1'b0;
        bus.m_nack                 = 1'b0;
        bus.m_start_err            = 1'b0;
        bus.m_arbitration_err      = 1'b0;
        bus.m_data_rx              = 8'h00;
        forever begin
            @(negedge clk_in);
            if (bus.m_transfer_start && bus.m_transfer_ready) run_txn();
        end
    end

    initial begin : rsp_monitor
        forever begin
            @(negedge clk_in);
            if (bus.rsp_valid) begin
                logic [10:0] got;
                got = {bus.rsp_rdata, bus.rsp_err_nack, bus.rsp_err_arb, bus.rsp_err_timeout};
                if (rsp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got 0x%0h, expected no response", got);
                end else begin
                    check("rsp", int'(got), int'(rsp_q.pop_front()));
                end
            end
        end
    end

    task automatic send_cmd(input logic rd, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        int n;
        n = 0;
        bus.cmd_read     = rd;
        bus.cmd_dev_addr = dev;
        bus.cmd_reg      = rg;
        bus.cmd_wdata    = wd;
        bus.cmd_valid    = 1'b1;
        while (!bus.cmd_ready && n < 1000) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 1000) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept: got no cmd_ready, expected acceptance within 1000 cycles");
        end
        @(negedge clk_in);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || !bus.m_transfer_ready) && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL completion: got %0d rsp / %0d bus items pending, expected 0", rsp_q.size(), bus_q.size());
        end
        repeat (3) @(negedge clk_in);
    endtask

    task automatic exp_write_bus(input logic [7:0] a, input logic [7:0] r, input logic [7:0] d);
        bus_q.push_back(TOK_START);
        bus_q.push_back(int'(a));
        bus_q.push_back(int'(r));
        bus_q.push_back(int'(d));
        bus_q.push_back(TOK_STOP);
    endtask

    function automatic int all_outputs();
        return int'({bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err_nack,
                     bus.rsp_err_arb, bus.rsp_err_timeout, bus.m_address,
                     bus.m_transfer_start, bus.m_transfer_continues, bus.m_data_tx});
    endfunction

    initial begin : stimulus
        int n;
        bus.cmd_valid    = 1'b0;
        bus.cmd_read     = 1'b0;
        bus.cmd_dev_addr = 7'h00;
        bus.cmd_reg      = 8'h00;
        bus.cmd_wdata    = 8'h00;
        repeat (3) @(negedge clk_in);
        check("reset_outputs", all_outputs(), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);

        // Write 0x50/0x10 <= 0xA5
        exp_write_bus(8'hA0, 8'h10, 8'hA5);
        rsp_q.push_back({8'h00, 3'b000});
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done();

        // Read 0x50/0x22, slave returns 0x3C, master NACKs the read byte
        slave_rd = 8'h3C;
        bus_q.push_back(TOK_START); bus_q.push_back(32'hA0); bus_q.push_back(32'h22);
        bus_q.push_back(TOK_STOP);
        bus_q.push_back(TOK_START); bus_q.push_back(32'hA1); bus_q.push_back(TOK_RNACK);
        bus_q.push_back(TOK_STOP);
        rsp_q.push_back({8'h3C, 3'b000});
        send_cmd(1'b1, 7'h50, 8'h22, 8'h99);
        wait_done();

        // Address NACK: no pointer byte, STOP, rdata cleared
        nack_idx = 0;
        bus_q.push_back(TOK_START); bus_q.push_back(32'hA0); bus_q.push_back(TOK_STOP);
        rsp_q.push_back({8'h00, 3'b100});
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done();

        // Pointer NACK: 0xA5 never sent
        nack_idx = 1;
        bus_q.push_back(TOK_START); bus_q.push_back(32'hA0); bus_q.push_back(32'h10);
        bus_q.push_back(TOK_STOP);
        rsp_q.push_back({8'h00, 3'b100});
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done();

        // Data NACK
        nack_idx = 2;
        exp_write_bus(8'hA0, 8'h10, 8'hA5);
        rsp_q.push_back({8'h00, 3'b100});
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done();

        // Arbitration loss on pointer byte (with nack also set): arb wins
        nack_idx = -1;
        arb_idx  = 1;
        bus_q.push_back(TOK_START); bus_q.push_back(32'hA0); bus_q.push_back(32'h10);
        bus_q.push_back(TOK_STOP);
        rsp_q.push_back({8'h00, 3'b010});
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done();
        arb_idx = -1;

        // Watchdog: master never interrupts after the address
        hang = 1'b1;
        bus_q.push_back(TOK_START); bus_q.push_back(32'hA0);
        rsp_q.push_back({8'h00, 3'b001});
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        check("timeout_latency", n, 65);
        wait_done();
        hang = 1'b0;

        // Different device/register/data; flags cleared from timeout
        exp_write_bus(8'h36, 8'hFF, 8'h00);
        rsp_q.push_back({8'h00, 3'b000});
        send_cmd(1'b0, 7'h1B, 8'hFF, 8'h00);
        wait_done();

        // Reset during WDATA: outputs cleared at once, no response
        exp_write_bus(8'hA0, 8'h10, 8'hA5);
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        n = 0;
        while (cur_byte != 2 && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        check("reach_wdata", int'(cur_byte == 2), 1);
        #2 reset = 1'b1;
        #1 check("reset_mid_cmd_outputs", all_outputs(), 0);
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        wait_done();
        repeat (20) @(negedge clk_in);

        // Write after reset recovers normally
        exp_write_bus(8'hA0, 8'h10, 8'hA5);
        rsp_q.push_back({8'h00, 3'b000});
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done();

        check("bus_q_empty", bus_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : time_limit
        #500us;
        $display("FAIL time_limit: got no end of run, expected finish within 500us");
        $fatal(1, "time limit");
    end
endmodule
